// File: rtl/config_byte_loader.sv
// config_byte_loader: parses header/payload/checksum byte frames into data and test configuration registers
package config_byte_loader_pkg;
    typedef struct packed {
        logic [12:0] mode;
        logic [31:0] value;
    } data_config_struct;
    typedef struct packed {
        logic        driver_valid;
        logic [68:0] settings;
    } test_config_struct;
endpackage

module config_byte_loader
    import config_byte_loader_pkg::*;
#(
    parameter logic [7:0] HDR_DATA = 8'hA1,
    parameter logic [7:0] HDR_TEST = 8'hA2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              cfg_lock,
    output data_config_struct data_cfg,
    output test_config_struct test_cfg,
    output logic              data_cfg_upd,
    output logic              test_cfg_upd,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);
    typedef enum logic [1:0] {HDR, PAY, CHK, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        tgt;
    logic [3:0]  cnt;
    logic [7:0]  csum;
    logic [71:0] shadow;
    logic        xfer, hdr_ok, last, match, commit, hdr_err, chk_err;

    assign byte_ready = !rst && state != COMMIT;
    assign busy       = state != HDR;
    assign xfer       = byte_valid && byte_ready;
    assign hdr_ok     = byte_in == HDR_DATA || byte_in == HDR_TEST;
    assign last       = cnt == (tgt ? 4'd8 : 4'd5);
    assign match      = byte_in == csum;
    assign hdr_err    = state == HDR && xfer && !hdr_ok;
    assign chk_err    = state == CHK && xfer && !match;
    assign commit     = !cfg_lock && ((state == CHK && xfer && match) || state == COMMIT);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else     state <= state_nxt;
    end

    // next-state: a locked commit parks in COMMIT until cfg_lock falls
    always_comb begin
        state_nxt = state;
        case (state)
            HDR:     state_nxt = xfer && hdr_ok ? PAY : HDR;
            PAY:     state_nxt = xfer && last ? CHK : PAY;
            CHK:     state_nxt = !xfer ? CHK : (match && cfg_lock ? COMMIT : HDR);
            default: state_nxt = cfg_lock ? COMMIT : HDR;
        endcase
    end

    // frame assembly, output registers and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt          <= 1'b0;
            cnt          <= '0;
            csum         <= '0;
            shadow       <= '0;
            data_cfg     <= '0;
            test_cfg     <= '0;
            data_cfg_upd <= 1'b0;
            test_cfg_upd <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            data_cfg_upd <= commit && !tgt;
            test_cfg_upd <= commit && tgt;
            err          <= hdr_err || chk_err;
            if (hdr_err) err_code <= 2'b01;
            else if (chk_err) err_code <= 2'b10;
            if (state == HDR && xfer && hdr_ok) begin
                tgt  <= byte_in == HDR_TEST;
                cnt  <= '0;
                csum <= byte_in;
            end
            if (state == PAY && xfer) begin
                shadow[{cnt, 3'b000} +: 8] <= byte_in;
                csum <= csum ^ byte_in;
                cnt  <= cnt + 4'd1;
            end
            if (commit && !tgt) data_cfg <= data_config_struct'(shadow[44:0]);
            if (commit && tgt) test_cfg <= test_config_struct'(shadow[69:0]);
            if (commit || chk_err) shadow <= '0;
        end
    end
endmodule

// File: tb/tb_config_byte_loader.sv
// tb_config_byte_loader: randomized scoreboard bench for config_byte_loader
module tb_config_byte_loader;
    import config_byte_loader_pkg::*;

    logic              clk = 0, rst = 1, byte_valid = 0, cfg_lock = 0;
    logic [7:0]        byte_in = 0;
    logic              byte_ready, data_cfg_upd, test_cfg_upd, err, busy;
    logic [1:0]        err_code;
    data_config_struct data_cfg;
    test_config_struct test_cfg;

    config_byte_loader dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .cfg_lock(cfg_lock), .data_cfg(data_cfg),
        .test_cfg(test_cfg), .data_cfg_upd(data_cfg_upd), .test_cfg_upd(test_cfg_upd),
        .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [69:0] val;
        logic [1:0]  code;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    logic [44:0] ref_data;
    logic [69:0] ref_test;
    logic [1:0]  ref_code;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pulses {err,data_upd,test_upd} are matched against the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ref_data = '0;
            ref_test = '0;
            ref_code = '0;
            check("ready_in_reset", 70'(byte_ready), 70'd0);
        end else begin
            check("err_upd_exclusive", 70'(err && (data_cfg_upd || test_cfg_upd)), 70'd0);
            if (err || data_cfg_upd || test_cfg_upd) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", 70'({err, data_cfg_upd, test_cfg_upd}), 70'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", 70'({err, data_cfg_upd, test_cfg_upd}), 70'(e.kind));
                    if (e.at >= 0) check("pulse_cycle", 70'(cyc), 70'(e.at));
                    if (e.kind == 3'b100) ref_code = e.code;
                    if (e.kind == 3'b010) ref_data = e.val[44:0];
                    if (e.kind == 3'b001) ref_test = e.val;
                end
            end
            check("data_cfg", 70'(data_cfg), 70'(ref_data));
            check("test_cfg", test_cfg, ref_test);
            check("err_code", 70'(err_code), 70'(ref_code));
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic send(input logic [7:0] b, output int c);
        int n = 0;
        @(negedge clk);
        byte_in = b;
        byte_valid = 1;
        while (!byte_ready) begin
            @(negedge clk);
            if (++n > 100) begin
                errors++;
                $display("FAIL send_timeout: byte_ready stuck low (cycle %0d)", cyc);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
        end
        @(posedge clk);
        #1 c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 0;
        end
    endtask

    task automatic frame(input logic [7:0] hdr, input logic [71:0] pay, input bit bad,
                         input int lock, input bit gaps);
        int         c;
        int         n = hdr == 8'hA1 ? 6 : 9;
        logic [7:0] x = hdr;
        logic [7:0] cs;
        exp_t       e;
        send(hdr, c);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(1) == 1) idle(1);
            send(pay[8*k +: 8], c);
            x ^= pay[8*k +: 8];
        end
        if (gaps && $urandom_range(1) == 1) idle(1);
        cs = bad ? (x == 8'hFF ? 8'h00 : 8'hFF) : x;
        cfg_lock = lock > 0;
        send(cs, c);
        e.val  = hdr == 8'hA1 ? {25'd0, pay[44:0]} : pay[69:0];
        e.kind = bad ? 3'b100 : (hdr == 8'hA1 ? 3'b010 : 3'b001);
        e.code = 2'b10;
        e.at   = c;
        if (!bad && lock > 0) begin
            repeat (lock) begin
                @(negedge clk);
                byte_valid = 0;
                check("ready_locked", 70'(byte_ready), 70'd0);
                check("busy_locked", 70'(busy), 70'd1);
            end
            cfg_lock = 0;
            e.at = cyc + 1;
        end
        q.push_back(e);
        idle(1);
        cfg_lock = 0;
    endtask

    task automatic bad_header(input logic [7:0] b);
        int   c;
        exp_t e;
        send(b, c);
        e.kind = 3'b100;
        e.val  = '0;
        e.code = 2'b01;
        e.at   = c;
        q.push_back(e);
        idle(1);
        check("busy_after_bad_hdr", 70'(busy), 70'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 0;
        rst = 1;
        idle(2);
        rst = 0;
    endtask

    initial begin
        int          c;
        logic [71:0] p;
        logic [7:0]  h;
        repeat (2) @(negedge clk);
        rst = 0;
        check("busy_reset", 70'(busy), 70'd0);
        frame(8'hA1, 72'h00_0006_0504_0302_01, 0, 0, 0);
        frame(8'hA2, 72'hFE_DCBA_9876_5432_1011, 0, 5, 0);
        bad_header(8'h5C);
        frame(8'hA1, 72'h00_00E5_1234_5678_9A, 0, 0, 0);
        frame(8'hA1, 72'h00_0077_6655_4433_22, 1, 0, 0);
        send(8'hA2, c);
        send(8'h11, c);
        send(8'h22, c);
        send(8'h33, c);
        do_reset();
        frame(8'hA2, 72'h3F_0102_0304_0506_0708, 0, 0, 0);
        frame(8'hA1, 72'h00_0006_0504_0302_01, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            p = {$urandom, $urandom, $urandom};
            if ($urandom_range(5) == 0) begin
                h = 8'($urandom);
                if (h == 8'hA1 || h == 8'hA2) h = 8'h00;
                bad_header(h);
            end else begin
                frame($urandom_range(1) == 1 ? 8'hA1 : 8'hA2, p, $urandom_range(3) == 0,
                      $urandom_range(3) == 0 ? int'($urandom_range(4, 1)) : 0, $urandom_range(1) == 1);
            end
        end
        idle(5);
        check("queue_empty", 70'(q.size()), 70'd0);
        finish_run();
    end
endmodule
